// File: rtl/fir_interp2_if.sv
// Valid/ready stream bundle for fir_interp2: sample input (s_*) and upsampled output (m_*).
interface fir_interp2_if #(
  parameter int unsigned DATA_W = 16
);
  logic                     s_valid;
  logic                     s_ready;
  logic signed [DATA_W-1:0] s_data;
  logic                     m_valid;
  logic                     m_ready;
  logic signed [DATA_W-1:0] m_data;
  logic                     m_phase;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_phase
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_phase
  );
endinterface

// File: rtl/fir_interp2.sv
// Two-phase Q15 interpolating FIR, upsample by 2: emits midpoint(x[n-1], x[n]) then x[n].
// Define FIR_INTERP2_ROUND_EN for round-half-up scaling; default is truncating >>>15.
module fir_interp2 #(
  parameter int unsigned        DATA_W = 16,
  parameter logic signed [15:0] C0     = 16'sd16384,
  parameter logic signed [15:0] C1     = 16'sd16384
) (
  input logic           clk,
  input logic           rst_n,
  fir_interp2_if.slave  bus
);

  localparam int unsigned ProdW = DATA_W + 16;
  localparam int unsigned SumW  = ProdW + 1;

  localparam logic signed [SumW-1:0] SatMax    = SumW'((1 <<< (DATA_W - 1)) - 1);
  localparam logic signed [SumW-1:0] SatMin    = -SatMax - SumW'(1);
  localparam logic signed [SumW-1:0] RoundBias = SumW'(16384);

  typedef enum logic [2:0] {StIdle, StMul, StSum, StOut0, StOut1} state_e;

  state_e                   state_q, state_d;
  logic signed [DATA_W-1:0] x_cur_q, x_cur_d;
  logic signed [DATA_W-1:0] x_prev_q, x_prev_d;
  logic signed [ProdW-1:0]  p0_q, p0_d;
  logic signed [ProdW-1:0]  p1_q, p1_d;
  logic signed [DATA_W-1:0] m_data_q, m_data_d;
  logic                     m_phase_q, m_phase_d;
  logic                     m_valid_q, m_valid_d;

  logic                     s_ready;
  logic signed [SumW-1:0]   sum;
  logic signed [SumW-1:0]   scaled;
  logic signed [DATA_W-1:0] sat;

  // Held low during reset so upstream never sees a spurious accept.
  assign s_ready = rst_n && ((state_q == StIdle) || ((state_q == StOut1) && bus.m_ready));

  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_phase = m_phase_q;

  always_comb begin
    sum = SumW'(p0_q) + SumW'(p1_q);
`ifdef FIR_INTERP2_ROUND_EN
    sum = sum + RoundBias;
`endif
    scaled = sum >>> 15;
    if (scaled > SatMax) begin
      sat = SatMax[DATA_W-1:0];
    end else if (scaled < SatMin) begin
      sat = SatMin[DATA_W-1:0];
    end else begin
      sat = scaled[DATA_W-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    x_cur_d   = x_cur_q;
    x_prev_d  = x_prev_q;
    p0_d      = p0_q;
    p1_d      = p1_q;
    m_data_d  = m_data_q;
    m_phase_d = m_phase_q;
    m_valid_d = m_valid_q;

    unique case (state_q)
      StIdle: begin
        if (bus.s_valid) begin
          x_cur_d  = bus.s_data;
          x_prev_d = x_cur_q;
          state_d  = StMul;
        end
      end
      StMul: begin
        p0_d    = ProdW'(C0) * ProdW'(x_prev_q);
        p1_d    = ProdW'(C1) * ProdW'(x_cur_q);
        state_d = StSum;
      end
      StSum: begin
        m_data_d  = sat;
        m_phase_d = 1'b0;
        m_valid_d = 1'b1;
        state_d   = StOut0;
      end
      StOut0: begin
        if (bus.m_ready) begin
          m_data_d  = x_cur_q;
          m_phase_d = 1'b1;
          state_d   = StOut1;
        end
      end
      StOut1: begin
        if (bus.m_ready) begin
          m_valid_d = 1'b0;
          if (bus.s_valid) begin
            x_cur_d  = bus.s_data;
            x_prev_d = x_cur_q;
            state_d  = StMul;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      x_cur_q   <= '0;
      x_prev_q  <= '0;
      p0_q      <= '0;
      p1_q      <= '0;
      m_data_q  <= '0;
      m_phase_q <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_cur_q   <= x_cur_d;
      x_prev_q  <= x_prev_d;
      p0_q      <= p0_d;
      p1_q      <= p1_d;
      m_data_q  <= m_data_d;
      m_phase_q <= m_phase_d;
      m_valid_q <= m_valid_d;
    end
  end

endmodule
